// File: rtl/adder_core.sv
// adder_core: registered WIDTH-bit add/subtract built on a two-level carry-lookahead adder.
// Build macro ADDER_FLAGS_EN adds registered carry (ARM-style) and signed overflow outputs.

module adder_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] opr0,
    input  logic [WIDTH-1:0] opr1,
    input  logic             minus,
    output logic             out_valid,
    output logic [WIDTH:0]   result,
    output logic             zero
`ifdef ADDER_FLAGS_EN
    ,
    output logic             carry,
    output logic             overflow
`endif
);

    localparam int NGRP = (WIDTH + 3) / 4;
    localparam int PW   = NGRP * 4;

    function automatic logic [1:0] group_gp(input logic [3:0] g, input logic [3:0] p);
        logic gg;
        logic pg;
        gg = g[3]
           | (p[3] & g[2])
           | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
        pg = &p;
        return {gg, pg};
    endfunction

    // Carries into bit positions 0..3 of one 4-bit group, all from the group carry-in.
    function automatic logic [3:0] group_carry(input logic [3:0] g, input logic [3:0] p,
                                               input logic cin);
        logic [3:0] c;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

    function automatic logic [NGRP:0] lookahead(input logic [NGRP-1:0] gg,
                                                input logic [NGRP-1:0] pg,
                                                input logic cin);
        logic [NGRP:0] c;
        logic          acc;
        logic          term;
        c[0] = cin;
        for (int k = 1; k <= NGRP; k++) begin
            // Flat sum-of-products per group carry: no ripple between groups.
            acc = cin;
            for (int i = 0; i < k; i++) acc = acc & pg[i];
            for (int j = 0; j < k; j++) begin
                term = gg[j];
                for (int i = j + 1; i < k; i++) term = term & pg[i];
                acc = acc | term;
            end
            c[k] = acc;
        end
        return c;
    endfunction

    logic [PW-1:0]   a_p0;
    logic [PW-1:0]   b_p0;
    logic [PW-1:0]   g_p0;
    logic [PW-1:0]   p_p0;
    logic [PW-1:0]   sum_p0;
    logic [NGRP-1:0] gg_p0;
    logic [NGRP-1:0] pg_p0;
    logic [NGRP:0]   cg_p0;
    logic [PW:0]     c_p0;
    logic            cout_p0;
    logic [WIDTH:0]  res_p0;
    logic            zero_p0;

    // Stage p0: operand conditioning, subtraction reuses the adder with inverted opr1 and cin=1
    always_comb begin
        a_p0 = '0;
        b_p0 = '0;
        a_p0[WIDTH-1:0] = opr0;
        b_p0[WIDTH-1:0] = minus ? ~opr1 : opr1;
        g_p0 = a_p0 & b_p0;
        p_p0 = a_p0 ^ b_p0;
    end

    always_comb begin
        gg_p0 = '0;
        pg_p0 = '0;
        for (int k = 0; k < NGRP; k++) begin
            {gg_p0[k], pg_p0[k]} = group_gp(g_p0[4*k +: 4], p_p0[4*k +: 4]);
        end
    end

    assign cg_p0 = lookahead(gg_p0, pg_p0, minus);

    always_comb begin
        c_p0 = '0;
        for (int k = 0; k < NGRP; k++) begin
            c_p0[4*k +: 4] = group_carry(g_p0[4*k +: 4], p_p0[4*k +: 4], cg_p0[k]);
        end
        c_p0[PW] = cg_p0[NGRP];
    end

    assign sum_p0  = p_p0 ^ c_p0[PW-1:0];
    assign cout_p0 = c_p0[WIDTH];
    // For subtract a missing carry-out means opr0 < opr1, i.e. borrow.
    assign res_p0  = {cout_p0 ^ minus, sum_p0[WIDTH-1:0]};
    assign zero_p0 = ~|sum_p0[WIDTH-1:0];

    logic           vld_p1;
    logic [WIDTH:0] result_p1;
    logic           zero_p1;

    // Stage p1: output registers, data held while in_valid is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            result_p1 <= '0;
            zero_p1   <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                result_p1 <= res_p0;
                zero_p1   <= zero_p0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign result    = result_p1;
    assign zero      = zero_p1;

`ifdef ADDER_FLAGS_EN
    logic carry_p0;
    logic ovf_p0;
    logic carry_p1;
    logic ovf_p1;

    // ARM-style carry is the raw adder carry-out in both modes; overflow is carry into vs out of the MSB.
    assign carry_p0 = cout_p0;
    assign ovf_p0   = c_p0[WIDTH] ^ c_p0[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_p1 <= 1'b0;
            ovf_p1   <= 1'b0;
        end else if (in_valid) begin
            carry_p1 <= carry_p0;
            ovf_p1   <= ovf_p0;
        end
    end

    assign carry    = carry_p1;
    assign overflow = ovf_p1;
`endif

endmodule

// File: tb/tb_adder_core.sv
// Scoreboard bench for adder_core: directed vectors, a back-to-back sweep, hold and async reset.
module tb_adder_core;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] opr0;
    logic [W-1:0] opr1;
    logic         minus;
    logic         out_valid;
    logic [W:0]   result;
    logic         zero;
`ifdef ADDER_FLAGS_EN
    logic         carry;
    logic         overflow;
`endif

    adder_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .opr0      (opr0),
        .opr1      (opr1),
        .minus     (minus),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero)
`ifdef ADDER_FLAGS_EN
        ,
        .carry     (carry),
        .overflow  (overflow)
`endif
    );

    typedef struct {
        logic [W:0] res;
        logic       z;
        logic       c;
        logic       v;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check33(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every valid output is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got out_valid=1 result=0x%0h expected no output", result);
            end else begin
                mon_e = sb.pop_front();
                pops++;
                check33("result", result, mon_e.res);
                check1("zero", zero, mon_e.z);
`ifdef ADDER_FLAGS_EN
                check1("carry", carry, mon_e.c);
                check1("overflow", overflow, mon_e.v);
`endif
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         input logic [W:0] er, input logic ez, input logic ec, input logic ev);
        exp_t e;
        opr0     = a;
        opr1     = b;
        minus    = m;
        in_valid = 1'b1;
        e.res = er;
        e.z   = ez;
        e.c   = ec;
        e.v   = ev;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        exp_t e;
        e.res = m ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        e.z   = (e.res[W-1:0] == '0);
        e.c   = m ? ~e.res[W] : e.res[W];
        e.v   = m ? ((a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]))
                  : ((a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]));
        return e;
    endfunction

    initial begin
        exp_t         r;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           pops0;

        rst_n    = 1'b1;
        in_valid = 1'b0;
        opr0     = '0;
        opr1     = '0;
        minus    = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check1("rst_out_valid", out_valid, 1'b0);
        check33("rst_result", result, 33'h0);
        check1("rst_zero", zero, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            idle();
            check1("post_rst_idle_valid", out_valid, 1'b0);
        end

        // a, b, minus, result, zero, carry, overflow
        issue(32'h00000005, 32'h00000003, 1'b0, 33'h0_00000008, 1'b0, 1'b0, 1'b0);
        issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h1_00000000, 1'b1, 1'b1, 1'b0);
        issue(32'h0000000A, 32'h0000000A, 1'b1, 33'h0_00000000, 1'b1, 1'b1, 1'b0);
        issue(32'h00000003, 32'h00000005, 1'b1, 33'h1_FFFFFFFE, 1'b0, 1'b0, 1'b0);
        issue(32'h00000000, 32'h00000001, 1'b1, 33'h1_FFFFFFFF, 1'b0, 1'b0, 1'b0);
        issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 33'h0_80000000, 1'b0, 1'b0, 1'b1);
        issue(32'h80000000, 32'h00000001, 1'b1, 33'h0_7FFFFFFF, 1'b0, 1'b1, 1'b1);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33'h1_FFFFFFFE, 1'b0, 1'b1, 1'b0);
        issue(32'h00000000, 32'h00000000, 1'b0, 33'h0_00000000, 1'b1, 1'b0, 1'b0);
        issue(32'h00000000, 32'h00000000, 1'b1, 33'h0_00000000, 1'b1, 1'b1, 1'b0);
        issue(32'hFFFFFFFF, 32'h00000000, 1'b1, 33'h0_FFFFFFFF, 1'b0, 1'b1, 1'b0);
        issue(32'h00000000, 32'hFFFFFFFF, 1'b1, 33'h1_00000001, 1'b0, 1'b0, 1'b0);
        issue(32'h80000000, 32'h80000000, 1'b0, 33'h1_00000000, 1'b1, 1'b1, 1'b1);
        issue(32'h0000FFFF, 32'h00000001, 1'b0, 33'h0_00010000, 1'b0, 1'b0, 1'b0);
        issue(32'h12345678, 32'h11111111, 1'b0, 33'h0_23456789, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            idle();
            check1("hold_valid", out_valid, 1'b0);
            check33("hold_result", result, 33'h0_23456789);
            check1("hold_zero", zero, 1'b0);
        end

        pops0 = pops;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 97 == 0) a = '1;
            if (i % 89 == 0) b = '0;
            r = ref_op(a, b, i[0]);
            issue(a, b, i[0], r.res, r.z, r.c, r.v);
        end
        idle();
        check_int("sweep_outputs", pops - pops0, 1000);
        check_int("sweep_drained", sb.size(), 0);

        issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h1_00000000, 1'b1, 1'b1, 1'b0);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check1("midrst_valid", out_valid, 1'b0);
        check33("midrst_result", result, 33'h0);
        check1("midrst_zero", zero, 1'b0);
`ifdef ADDER_FLAGS_EN
        check1("midrst_carry", carry, 1'b0);
        check1("midrst_overflow", overflow, 1'b0);
`endif
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            idle();
            check1("midrst_idle_valid", out_valid, 1'b0);
        end
        check_int("final_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
